// File: rtl/rom_loader_if.sv
// Byte-stream input, ROM write port and load status of the ROM loader.
//   master: stream/control source (drives start_i, byte_i, byte_valid_i)
//   slave : rom_loader (accepts bytes, drives the ROM write port and status)
interface rom_loader_if #(
    parameter int unsigned CNT_W = 13
);
    logic             start_i;
    logic [7:0]       byte_i;
    logic             byte_valid_i;
    logic             byte_ready_o;
    logic             we_o;
    logic [31:0]      addr_o;
    logic [31:0]      data_o;
    logic             hold_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [CNT_W-1:0] word_cnt_o;

    modport master (
        output start_i, byte_i, byte_valid_i,
        input  byte_ready_o, we_o, addr_o, data_o, hold_o, busy_o,
               done_o, err_o, word_cnt_o
    );

    modport slave (
        input  start_i, byte_i, byte_valid_i,
        output byte_ready_o, we_o, addr_o, data_o, hold_o, busy_o,
               done_o, err_o, word_cnt_o
    );
endinterface

// File: rtl/rom_loader.sv
// Loads the instruction ROM from a byte stream: 4-byte LE word count, then
// that many LE 32-bit words written to BASE_ADDR + 4*i. Holds the core in
// reset while loading and reports done/error.
// Ports: clk, rst_n (synchronous, active-low), bus (rom_loader_if.slave).
module rom_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096,
    parameter int unsigned TIMEOUT   = 1000000,
    parameter int unsigned CNT_W     = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    rom_loader_if.slave  bus
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t           state;
    logic [23:0]      shift_q;
    logic [1:0]       idx_q;
    logic [CNT_W-1:0] len_q;
    logic [TMO_W-1:0] tmo_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      data_q;
    logic             hold_q;
    logic             done_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic             ready_c;
    logic             accept_c;
    logic [31:0]      word_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             tmo_hit_c;

    assign ready_c   = (state == S_LEN) || (state == S_DATA);
    assign accept_c  = bus.byte_valid_i & ready_c;
    // Three earlier bytes sit in the shift register; the current byte is the MSB.
    assign word_c    = {bus.byte_i, shift_q};
    assign cnt_inc_c = cnt_q + CNT_W'(1);
    assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT - 1));

    // Loader FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start_i) begin
                        state  <= S_LEN;
                        hold_q <= 1'b1;
                        err_q  <= 1'b0;
                        cnt_q  <= '0;
                        idx_q  <= '0;
                        tmo_q  <= '0;
                    end else if (state == S_DONE) begin
                        state <= S_IDLE;
                    end
                end
                S_LEN, S_DATA: begin
                    if (accept_c) begin
                        tmo_q   <= '0;
                        idx_q   <= idx_q + 2'd1;
                        shift_q <= {bus.byte_i, shift_q[23:8]};
                        if (idx_q == 2'd3) begin
                            if (state == S_LEN) begin
                                len_q <= CNT_W'(word_c);
                                if (word_c == 32'd0) begin
                                    state  <= S_DONE;
                                    done_q <= 1'b1;
                                    hold_q <= 1'b0;
                                end else if (word_c > 32'(MAX_WORDS)) begin
                                    state  <= S_ERR;
                                    err_q  <= 1'b1;
                                    hold_q <= 1'b0;
                                end else begin
                                    state <= S_DATA;
                                end
                            end else begin
                                state  <= S_WRITE;
                                we_q   <= 1'b1;
                                data_q <= word_c;
                                addr_q <= BASE_ADDR + 32'({cnt_q, 2'b00});
                            end
                        end
                    end else if (tmo_hit_c) begin
                        state  <= S_ERR;
                        err_q  <= 1'b1;
                        hold_q <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_WRITE: begin
                    cnt_q <= cnt_inc_c;
                    if (cnt_inc_c == len_q) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        hold_q <= 1'b0;
                    end else begin
                        state <= S_DATA;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.byte_ready_o = ready_c;
    assign bus.busy_o       = ready_c || (state == S_WRITE);
    assign bus.we_o         = we_q;
    assign bus.addr_o       = addr_q;
    assign bus.data_o       = data_q;
    assign bus.hold_o       = hold_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;
    assign bus.word_cnt_o   = cnt_q;
endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Write-side initiator for the instruction ROM: drives its we/addr/data write port from a byte stream, such as a UART receiver or a debug bridge.
- On a start pulse it reads a 4-byte little-endian word count, then that many 32-bit little-endian words. Each word is written to consecutive word addresses starting at BASE_ADDR.
- Holds the core in reset (hold_o) while loading, and reports done or error.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word (word-aligned).
- MAX_WORDS, 4096, maximum accepted word count (matches ROM depth).
- TIMEOUT, 1000000, idle cycles without an accepted byte before aborting.
- CNT_W, 13, width of word counters (holds 0..MAX_WORDS).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start_i  in  1  one-cycle start request; honoured only in IDLE, DONE or ERR.
- byte_i  in  8  incoming stream byte.
- byte_valid_i  in  1  byte_i valid.
- byte_ready_o  out  1  loader accepts a byte; transfer when valid & ready.
- we_o  out  1  ROM write enable, one cycle per word.
- addr_o  out  32  ROM byte address.
- data_o  out  32  ROM write data.
- hold_o  out  1  keep the CPU core in reset while a load is in progress.
- busy_o  out  1  high in LEN, DATA and WRITE.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  sticky error flag, cleared by the next accepted start_i.
- word_cnt_o  out  CNT_W  number of words written in the current or last load.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - we_o=0, addr_o=BASE_ADDR, data_o=0, byte_ready_o=0, hold_o=0, busy_o=0, done_o=0, err_o=0, word_cnt_o=0.
  - Byte shift register, length register, byte index and timeout counter are cleared.
  - Reset mid-load abandons the load immediately; no further writes are issued.
- States: IDLE, LEN, DATA, WRITE, DONE, ERR.
- Byte acceptance:
  - byte_ready_o is 1 only in LEN and DATA (decoded from state).
  - A byte is accepted when byte_valid_i & byte_ready_o are both high at an edge.
  - byte_i is ignored in all other states.
- Byte assembly:
  - Little-endian: the first byte accepted fills [7:0], the fourth fills [31:24].
  - A 2-bit byte index wraps 3 to 0 after the fourth byte.
- IDLE / DONE / ERR:
  - On start_i: go to LEN, clear err_o, word_cnt_o, byte index and timeout counter.
  - start_i in LEN, DATA or WRITE is ignored.
- LEN:
  - After the 4th accepted byte the 32-bit length L is latched.
  - L==0: go to DONE (no writes, done_o pulse).
  - L>MAX_WORDS: go to ERR.
  - Otherwise: go to DATA.
- DATA:
  - After the 4th accepted byte, latch the word into data_o and go to WRITE.
- WRITE (exactly one cycle):
  - we_o=1, addr_o=BASE_ADDR+(word_cnt_o<<2), data_o=assembled word.
  - At the edge ending WRITE, word_cnt_o increments.
  - If the new count == L: go to DONE; else go back to DATA.
  - Write latency: the WRITE cycle immediately follows the edge that accepted the 4th byte.
- DONE:
  - done_o=1 for that one cycle, hold_o=0, then go to IDLE unless start_i is asserted.
  - word_cnt_o keeps its value.
- ERR:
  - err_o=1 and hold_o=0, held until an accepted start_i.
- hold_o:
  - Set to 1 on the edge entering LEN; stays 1 through LEN, DATA and WRITE.
  - Drops on entering DONE or ERR.
- Timeout:
  - The counter runs in LEN and DATA and clears on every accepted byte.
  - When it reaches TIMEOUT-1 with no byte accepted: go to ERR.
  - No write is issued for a partial word.
- Between writes:
  - we_o is 0 outside WRITE.
  - addr_o and data_o hold their last values (ROM ignores them when we_o=0).
- Address arithmetic:
  - 32-bit, BASE_ADDR + 4*index; wrap-around beyond 2^32 is not checked (L ≤ MAX_WORDS bounds it).
- Back-pressure:
  - byte_valid_i held high during WRITE is not consumed.
  - The next byte is accepted in the first DATA cycle after WRITE.

Test Plan:
- Normal 2-word load:
  - Stimulus: start, then bytes 02 00 00 00, 78 56 34 12, EF BE AD DE with valid held high, BASE_ADDR=0.
  - Response: we_o pulses with (0x0, 0x12345678) then (0x4, 0xDEADBEEF), then done_o for one cycle, word_cnt_o=2.
  - hold_o high from the cycle after start until DONE.
- Zero length:
  - Stimulus: start, then bytes 00 00 00 00.
  - Response: no we_o, done_o pulse, word_cnt_o=0, err_o=0.
- Oversize length:
  - Stimulus: length 0x00001001 (4097).
  - Response: ERR, err_o=1, hold_o=0, no we_o; a following start clears err_o.
- Gapped stream:
  - Stimulus: 1-word load with byte_valid_i toggling every other cycle.
  - Response: exactly one write of the correct word; byte_ready_o=0 during the WRITE cycle.
- Timeout:
  - Stimulus: TIMEOUT=16, length 1, then only 2 data bytes, then idle.
  - Response: err_o rises 16 cycles after the last accepted byte; no we_o.
- Reset and start-ignore:
  - Stimulus: rst_n low mid-DATA of a 3-word load after 1 word written; separately, start_i pulsed while busy.
  - Response: after reset, all outputs at reset values and no further we_o; the start pulsed while busy changes nothing.
